// File: rtl/sata_cont_pkg.sv
// Shared primitive codes, dword constants, FSM state types and helpers for the
// CONT suppression engine (cont_engine) and its RX tracker.
package sata_cont_pkg;

    typedef enum logic [3:0] {
        PRIM_NONE    = 4'd0,
        PRIM_ALIGN   = 4'd1,
        PRIM_SOF     = 4'd2,
        PRIM_EOF     = 4'd3,
        PRIM_CONT    = 4'd4,
        PRIM_SYNC    = 4'd5,
        PRIM_R_RDY   = 4'd6,
        PRIM_R_IP    = 4'd7,
        PRIM_R_ERR   = 4'd8,
        PRIM_R_OK    = 4'd9,
        PRIM_X_RDY   = 4'd10,
        PRIM_WTRM    = 4'd11,
        PRIM_HOLD    = 4'd12,
        PRIM_HOLDA   = 4'd13,
        PRIM_PMREQ_S = 4'd14,
        PRIM_PMREQ_P = 4'd15
    } prim_e;

    typedef enum logic [1:0] {TX_PASS, TX_COUNT, TX_CONT, TX_JUNK} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_SEEN, RX_ARMED, RX_CONT} rx_state_e;

    localparam logic [31:0] DW_ALIGN   = 32'h7B4A_4ABC;
    localparam logic [31:0] DW_SOF     = 32'h3737_B57C;
    localparam logic [31:0] DW_EOF     = 32'hD5D5_B57C;
    localparam logic [31:0] DW_CONT    = 32'h9999_AA7C;
    localparam logic [31:0] DW_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] DW_R_RDY   = 32'h4A4A_957C;
    localparam logic [31:0] DW_R_IP    = 32'h5555_B57C;
    localparam logic [31:0] DW_R_ERR   = 32'h5656_B57C;
    localparam logic [31:0] DW_R_OK    = 32'h3535_B57C;
    localparam logic [31:0] DW_X_RDY   = 32'h5757_B57C;
    localparam logic [31:0] DW_WTRM    = 32'h5858_B57C;
    localparam logic [31:0] DW_HOLD    = 32'hD5D5_AA7C;
    localparam logic [31:0] DW_HOLDA   = 32'h9595_AA7C;
    localparam logic [31:0] DW_PMREQ_S = 32'h7575_957C;
    localparam logic [31:0] DW_PMREQ_P = 32'h1717_B57C;

    localparam logic [31:0] JUNK_TAPS  = 32'h8020_0003;

    function automatic prim_e decode_prim(input logic [31:0] dw);
        case (dw)
            DW_ALIGN:   return PRIM_ALIGN;
            DW_SOF:     return PRIM_SOF;
            DW_EOF:     return PRIM_EOF;
            DW_CONT:    return PRIM_CONT;
            DW_SYNC:    return PRIM_SYNC;
            DW_R_RDY:   return PRIM_R_RDY;
            DW_R_IP:    return PRIM_R_IP;
            DW_R_ERR:   return PRIM_R_ERR;
            DW_R_OK:    return PRIM_R_OK;
            DW_X_RDY:   return PRIM_X_RDY;
            DW_WTRM:    return PRIM_WTRM;
            DW_HOLD:    return PRIM_HOLD;
            DW_HOLDA:   return PRIM_HOLDA;
            DW_PMREQ_S: return PRIM_PMREQ_S;
            DW_PMREQ_P: return PRIM_PMREQ_P;
            default:    return PRIM_NONE;
        endcase
    endfunction

    function automatic logic is_repeatable(input prim_e p);
        case (p)
            PRIM_SYNC, PRIM_R_RDY, PRIM_R_IP, PRIM_R_ERR, PRIM_R_OK, PRIM_X_RDY,
            PRIM_WTRM, PRIM_HOLD, PRIM_HOLDA, PRIM_PMREQ_S, PRIM_PMREQ_P: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Galois LFSR step used as the junk-dword scrambler.
    function automatic logic [31:0] junk_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ JUNK_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/cont_engine_if.sv
// Link-layer / PHY side signal bundle of cont_engine; master drives the
// link-layer and PHY inputs, slave is the engine.
interface cont_engine_if;
    logic        phy_ready;
    logic        xmit_cont_en;
    logic        last_prim;
    logic [31:0] ll_tx_din;
    logic        ll_tx_is_k;
    logic [31:0] cont_tx_dout;
    logic        cont_tx_is_k;
    logic [31:0] rx_din;
    logic [3:0]  rx_is_k;
    logic        rx_prim_valid;
    logic [3:0]  rx_prim_code;
    logic        rx_prim_cont;
    logic        detect_xrdy_xrdy;
    logic [15:0] tx_cont_count;
    logic [15:0] rx_cont_count;
    logic [15:0] rx_cont_err;

    modport master (
        output phy_ready, xmit_cont_en, last_prim, ll_tx_din, ll_tx_is_k, rx_din, rx_is_k,
        input  cont_tx_dout, cont_tx_is_k, rx_prim_valid, rx_prim_code, rx_prim_cont,
               detect_xrdy_xrdy, tx_cont_count, rx_cont_count, rx_cont_err
    );

    modport slave (
        input  phy_ready, xmit_cont_en, last_prim, ll_tx_din, ll_tx_is_k, rx_din, rx_is_k,
        output cont_tx_dout, cont_tx_is_k, rx_prim_valid, rx_prim_code, rx_prim_cont,
               detect_xrdy_xrdy, tx_cont_count, rx_cont_count, rx_cont_err
    );
endinterface

// File: rtl/cont_rx_tracker.sv
// RX side of the CONT engine: decodes PHY dwords into primitive codes and
// regenerates the held primitive while a CONT run is active.
//   state    | meaning
//   RX_IDLE  | no repeatable primitive being tracked
//   RX_SEEN  | repeatable primitive seen, fewer than RX_REPEAT_MIN times
//   RX_ARMED | enough repeats seen; a CONT now starts a run
//   RX_CONT  | inside a CONT run, held primitive regenerated every beat
module cont_rx_tracker
    import sata_cont_pkg::*;
#(
    parameter int RX_REPEAT_MIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic [31:0] rx_din,
    input  logic        rx_is_k,
    output logic        prim_valid,
    output prim_e       prim_code,
    output logic        prim_cont,
    output logic        cont_entered,
    output logic        cont_err
);

    localparam logic [3:0] RX_MIN = 4'(RX_REPEAT_MIN);

    rx_state_e  state, state_n;
    logic [3:0] rcnt, rcnt_n, rcnt_inc;
    prim_e      held, held_n;
    prim_e      prim;

    assign prim     = rx_is_k ? decode_prim(rx_din) : PRIM_NONE;
    assign rcnt_inc = (rcnt == 4'hF) ? rcnt : rcnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
            rcnt  <= 4'd0;
            held  <= PRIM_NONE;
        end else begin
            state <= state_n;
            rcnt  <= rcnt_n;
            held  <= held_n;
        end
    end

    always_comb begin
        state_n      = state;
        rcnt_n       = rcnt;
        held_n       = held;
        prim_valid   = 1'b0;
        prim_code    = PRIM_NONE;
        prim_cont    = 1'b0;
        cont_entered = 1'b0;
        cont_err     = 1'b0;
        if (!phy_ready) begin
            state_n = RX_IDLE;
            rcnt_n  = 4'd0;
        end else if (prim == PRIM_ALIGN) begin
            prim_valid = 1'b1;
            prim_code  = PRIM_ALIGN;
        end else if (!rx_is_k) begin
            if (state == RX_CONT) begin
                prim_valid = 1'b1;
                prim_code  = held;
                prim_cont  = 1'b1;
            end else begin
                state_n = RX_IDLE;
                rcnt_n  = 4'd0;
            end
        end else if (prim == PRIM_CONT) begin
            case (state)
                RX_CONT: begin
                    prim_valid = 1'b1;
                    prim_code  = held;
                    prim_cont  = 1'b1;
                end
                RX_ARMED: begin
                    prim_valid   = 1'b1;
                    prim_code    = held;
                    prim_cont    = 1'b1;
                    cont_entered = 1'b1;
                    state_n      = RX_CONT;
                end
                default: cont_err = 1'b1;
            endcase
        end else begin
            prim_valid = (prim != PRIM_NONE);
            prim_code  = prim;
            if (is_repeatable(prim)) begin
                if (state != RX_IDLE && prim == held) begin
                    rcnt_n = rcnt_inc;
                end else begin
                    rcnt_n = 4'd1;
                    held_n = prim;
                end
                state_n = (rcnt_n >= RX_MIN) ? RX_ARMED : RX_SEEN;
            end else begin
                state_n = RX_IDLE;
                rcnt_n  = 4'd0;
            end
        end
    end

endmodule

// File: rtl/cont_engine.sv
// CONT primitive suppression engine between link layer and PHY: TX FSM and
// junk scrambler here, RX tracking in cont_rx_tracker. Stats need CONT_STATS_EN.
//   state    | meaning
//   TX_PASS  | passthrough, no repeat run in progress
//   TX_COUNT | passthrough, counting identical repeatable primitives
//   TX_CONT  | next identical beat is replaced by CONT
//   TX_JUNK  | identical beats replaced by scrambled junk
module cont_engine
    import sata_cont_pkg::*;
#(
    parameter int          TX_REPEAT_MIN = 2,
    parameter int          RX_REPEAT_MIN = 2,
    parameter logic [31:0] JUNK_SEED     = 32'hFFFF
) (
    input logic          clk,
    input logic          rst,
    cont_engine_if.slave bus
);

    localparam logic [3:0] TX_MIN = 4'(TX_REPEAT_MIN);

    tx_state_e   tx_state, tx_state_n;
    logic [3:0]  cnt, cnt_n, cnt_inc;
    logic [31:0] prev, prev_n, junk, junk_n;
    prim_e       tx_prim, rx_code;
    logic        tx_align, tx_rep, tx_same, tx_cont_hit;
    logic        rx_valid, rx_cont, rx_cont_hit, rx_cont_bad;
    logic        unused_rx_k;

    assign tx_prim  = decode_prim(bus.ll_tx_din);
    assign tx_align = bus.ll_tx_is_k && (tx_prim == PRIM_ALIGN);
    assign tx_rep   = bus.ll_tx_is_k && is_repeatable(tx_prim);
    assign tx_same  = tx_rep && !bus.last_prim && (bus.ll_tx_din == prev);
    assign cnt_inc  = cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_PASS;
            cnt      <= 4'd0;
            prev     <= 32'h0;
            junk     <= JUNK_SEED;
        end else begin
            tx_state <= tx_state_n;
            cnt      <= cnt_n;
            prev     <= prev_n;
            junk     <= junk_n;
        end
    end

    // Any break in the run passes the new beat through in the same cycle.
    always_comb begin
        tx_state_n       = tx_state;
        cnt_n            = cnt;
        prev_n           = prev;
        junk_n           = junk;
        tx_cont_hit      = 1'b0;
        bus.cont_tx_dout = bus.ll_tx_din;
        bus.cont_tx_is_k = bus.ll_tx_is_k;
        if (!bus.phy_ready || tx_align) begin
            tx_state_n = tx_state;
        end else if (!bus.xmit_cont_en) begin
            tx_state_n = TX_PASS;
            cnt_n      = 4'd0;
            prev_n     = bus.ll_tx_din;
        end else if (!tx_same) begin
            tx_state_n = TX_PASS;
            cnt_n      = tx_rep ? 4'd1 : 4'd0;
            prev_n     = bus.ll_tx_din;
        end else begin
            case (tx_state)
                TX_CONT: begin
                    bus.cont_tx_dout = DW_CONT;
                    bus.cont_tx_is_k = 1'b1;
                    tx_cont_hit      = 1'b1;
                    tx_state_n       = TX_JUNK;
                end
                TX_JUNK: begin
                    bus.cont_tx_dout = junk;
                    bus.cont_tx_is_k = 1'b0;
                    junk_n           = junk_next(junk);
                end
                default: begin
                    cnt_n      = cnt_inc;
                    tx_state_n = (cnt_inc >= TX_MIN) ? TX_CONT : TX_COUNT;
                end
            endcase
        end
    end

    cont_rx_tracker #(.RX_REPEAT_MIN(RX_REPEAT_MIN)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .phy_ready    (bus.phy_ready),
        .rx_din       (bus.rx_din),
        .rx_is_k      (bus.rx_is_k[0]),
        .prim_valid   (rx_valid),
        .prim_code    (rx_code),
        .prim_cont    (rx_cont),
        .cont_entered (rx_cont_hit),
        .cont_err     (rx_cont_bad)
    );

    assign bus.rx_prim_valid    = rx_valid;
    assign bus.rx_prim_code     = rx_code;
    assign bus.rx_prim_cont     = rx_cont;
    assign bus.detect_xrdy_xrdy = bus.ll_tx_is_k && (tx_prim == PRIM_X_RDY) &&
                                  rx_valid && (rx_code == PRIM_X_RDY);
    assign unused_rx_k          = ^bus.rx_is_k[3:1];

`ifdef CONT_STATS_EN
    logic [15:0] tx_cnt_q, rx_cnt_q, rx_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q <= 16'h0;
            rx_cnt_q <= 16'h0;
            rx_err_q <= 16'h0;
        end else begin
            if (tx_cont_hit && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
            if (rx_cont_hit && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
            if (rx_cont_bad && rx_err_q != 16'hFFFF) rx_err_q <= rx_err_q + 16'd1;
        end
    end

    assign bus.tx_cont_count = tx_cnt_q;
    assign bus.rx_cont_count = rx_cnt_q;
    assign bus.rx_cont_err   = rx_err_q;
`else
    logic unused_stats;
    assign unused_stats      = ^{tx_cont_hit, rx_cont_hit, rx_cont_bad};
    assign bus.tx_cont_count = 16'h0;
    assign bus.rx_cont_count = 16'h0;
    assign bus.rx_cont_err   = 16'h0;
`endif

endmodule

// File: tb/tb_cont_engine.sv
// Directed scoreboard bench for cont_engine with default parameters.
module tb_cont_engine;
    import sata_cont_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        k;
        logic        rv;
        logic [3:0]  rc;
        logic        rcont;
        logic        det;
    } exp_t;

`ifdef CONT_STATS_EN
    localparam logic STATS_ON = 1'b1;
`else
    localparam logic STATS_ON = 1'b0;
`endif

    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] jstate;

    always #5 clk = ~clk;

    cont_engine_if bus_if ();
    cont_engine dut (.clk(clk), .rst(rst), .bus(bus_if));

    function automatic logic [31:0] jnext(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    function automatic logic [15:0] stat_exp(input int n);
        return STATS_ON ? 16'(n) : 16'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_stats(input string tag, input int ntx, input int nrx, input int nerr);
        check({tag, ".tx_cont_count"}, 32'(bus_if.tx_cont_count), 32'(stat_exp(ntx)));
        check({tag, ".rx_cont_count"}, 32'(bus_if.rx_cont_count), 32'(stat_exp(nrx)));
        check({tag, ".rx_cont_err"}, 32'(bus_if.rx_cont_err), 32'(stat_exp(nerr)));
    endtask

    // Drives one beat, pushes its expectation, then compares at the negedge.
    task automatic step(input string tag, input logic [31:0] tdin, input logic tk, input logic lp,
                        input logic [31:0] rdin, input logic rk, input logic jnk,
                        input logic [31:0] edout, input logic ek, input logic rv,
                        input logic [3:0] rc, input logic rcont, input logic det);
        exp_t e, o;
        bus_if.ll_tx_din  = tdin;
        bus_if.ll_tx_is_k = tk;
        bus_if.last_prim  = lp;
        bus_if.rx_din     = rdin;
        bus_if.rx_is_k    = {3'b000, rk};
        e.tag   = tag;
        e.dout  = jnk ? jstate : edout;
        e.k     = jnk ? 1'b0 : ek;
        e.rv    = rv;
        e.rc    = rc;
        e.rcont = rcont;
        e.det   = det;
        if (jnk) jstate = jnext(jstate);
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check({o.tag, ".dout"}, bus_if.cont_tx_dout, o.dout);
        check({o.tag, ".is_k"}, 32'(bus_if.cont_tx_is_k), 32'(o.k));
        check({o.tag, ".rx_valid"}, 32'(bus_if.rx_prim_valid), 32'(o.rv));
        if (o.rv) check({o.tag, ".rx_code"}, 32'(bus_if.rx_prim_code), 32'(o.rc));
        check({o.tag, ".rx_cont"}, 32'(bus_if.rx_prim_cont), 32'(o.rcont));
        check({o.tag, ".detect"}, 32'(bus_if.detect_xrdy_xrdy), 32'(o.det));
        @(posedge clk);
        #1;
    endtask

    task automatic txs(input string tag, input logic [31:0] tdin, input logic lp,
                       input logic jnk, input logic [31:0] edout, input logic ek);
        step(tag, tdin, 1'b1, lp, D2, 1'b0, jnk, edout, ek, 1'b0, PRIM_NONE, 1'b0, 1'b0);
    endtask

    task automatic rxs(input string tag, input logic [31:0] rdin, input logic rk,
                       input logic rv, input logic [3:0] rc, input logic rcont);
        step(tag, D1, 1'b0, 1'b0, rdin, rk, 1'b0, D1, 1'b0, rv, rc, rcont, 1'b0);
    endtask

    initial begin
        rst                 = 1'b1;
        jstate              = 32'hFFFF;
        bus_if.phy_ready    = 1'b1;
        bus_if.xmit_cont_en = 1'b1;
        bus_if.last_prim    = 1'b0;
        bus_if.ll_tx_din    = D1;
        bus_if.ll_tx_is_k   = 1'b0;
        bus_if.rx_din       = D2;
        bus_if.rx_is_k      = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_stats("reset", 0, 0, 0);

        // SYNC run: two verbatim, CONT, then junk
        txs("sync1", DW_SYNC, 1'b0, 1'b0, DW_SYNC, 1'b1);
        txs("sync2", DW_SYNC, 1'b0, 1'b0, DW_SYNC, 1'b1);
        txs("sync_cont", DW_SYNC, 1'b0, 1'b0, DW_CONT, 1'b1);
        for (int i = 0; i < 3; i++) txs("sync_junk", DW_SYNC, 1'b0, 1'b1, 32'h0, 1'b0);
        check_stats("sync_run", 1, 0, 0);

        // change of primitive during junk
        txs("rok_break", DW_R_OK, 1'b0, 1'b0, DW_R_OK, 1'b1);
        txs("rok2", DW_R_OK, 1'b0, 1'b0, DW_R_OK, 1'b1);
        txs("rok_cont", DW_R_OK, 1'b0, 1'b0, DW_CONT, 1'b1);
        txs("rok_junk", DW_R_OK, 1'b0, 1'b1, 32'h0, 1'b0);

        // ALIGN passes through without disturbing the run
        txs("align_pass", DW_ALIGN, 1'b0, 1'b0, DW_ALIGN, 1'b1);
        txs("post_align", DW_R_OK, 1'b0, 1'b1, 32'h0, 1'b0);

        // last_prim forces verbatim and restarts the count
        txs("last_prim", DW_R_OK, 1'b1, 1'b0, DW_R_OK, 1'b1);
        txs("lp_next", DW_R_OK, 1'b0, 1'b0, DW_R_OK, 1'b1);
        txs("lp_cont", DW_R_OK, 1'b0, 1'b0, DW_CONT, 1'b1);
        txs("lp_junk", DW_R_OK, 1'b0, 1'b1, 32'h0, 1'b0);

        // PHY down freezes the state
        bus_if.phy_ready = 1'b0;
        txs("phy_down", DW_R_OK, 1'b0, 1'b0, DW_R_OK, 1'b1);
        bus_if.phy_ready = 1'b1;
        txs("phy_up", DW_R_OK, 1'b0, 1'b1, 32'h0, 1'b0);

        // suppression disabled
        bus_if.xmit_cont_en = 1'b0;
        txs("xmit_off", DW_R_OK, 1'b0, 1'b0, DW_R_OK, 1'b1);
        bus_if.xmit_cont_en = 1'b1;
        txs("xmit_on", DW_R_OK, 1'b0, 1'b0, DW_R_OK, 1'b1);
        step("tx_nonk", D1, 1'b0, 1'b0, D2, 1'b0, 1'b0, D1, 1'b0, 1'b0, PRIM_NONE, 1'b0, 1'b0);
        check_stats("tx_done", 3, 0, 0);

        // RX CONT run regenerates HOLD
        rxs("rx_hold1", DW_HOLD, 1'b1, 1'b1, PRIM_HOLD, 1'b0);
        rxs("rx_hold2", DW_HOLD, 1'b1, 1'b1, PRIM_HOLD, 1'b0);
        rxs("rx_cont", DW_CONT, 1'b1, 1'b1, PRIM_HOLD, 1'b1);
        rxs("rx_junk1", 32'hC0DE_0001, 1'b0, 1'b1, PRIM_HOLD, 1'b1);
        rxs("rx_junk2", 32'hC0DE_0002, 1'b0, 1'b1, PRIM_HOLD, 1'b1);
        rxs("rx_junk3", 32'hC0DE_0003, 1'b0, 1'b1, PRIM_HOLD, 1'b1);
        rxs("rx_align", DW_ALIGN, 1'b1, 1'b1, PRIM_ALIGN, 1'b0);
        rxs("rx_junk4", 32'hC0DE_0004, 1'b0, 1'b1, PRIM_HOLD, 1'b1);
        check_stats("rx_run", 3, 1, 0);
        rxs("rx_sof", DW_SOF, 1'b1, 1'b1, PRIM_SOF, 1'b0);
        rxs("rx_idle", D2, 1'b0, 1'b0, PRIM_NONE, 1'b0);

        // single X_RDY then CONT is not honoured; X_RDY/X_RDY detect
        step("xrdy_det", DW_X_RDY, 1'b1, 1'b0, DW_X_RDY, 1'b1, 1'b0, DW_X_RDY, 1'b1,
             1'b1, PRIM_X_RDY, 1'b0, 1'b1);
        step("cont_ignored", DW_X_RDY, 1'b1, 1'b0, DW_CONT, 1'b1, 1'b0, DW_X_RDY, 1'b1,
             1'b0, PRIM_NONE, 1'b0, 1'b0);
        check_stats("cont_err", 3, 1, 1);
        rxs("xrdy_no_tx", DW_X_RDY, 1'b1, 1'b1, PRIM_X_RDY, 1'b0);

        // reset in the middle of TX_JUNK and RX_CONT
        step("r_s1", DW_SYNC, 1'b1, 1'b0, DW_HOLD, 1'b1, 1'b0, DW_SYNC, 1'b1, 1'b1, PRIM_HOLD, 1'b0, 1'b0);
        step("r_s2", DW_SYNC, 1'b1, 1'b0, DW_HOLD, 1'b1, 1'b0, DW_SYNC, 1'b1, 1'b1, PRIM_HOLD, 1'b0, 1'b0);
        step("r_cont", DW_SYNC, 1'b1, 1'b0, DW_CONT, 1'b1, 1'b0, DW_CONT, 1'b1, 1'b1, PRIM_HOLD, 1'b1, 1'b0);
        step("r_junk", DW_SYNC, 1'b1, 1'b0, D2, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, PRIM_HOLD, 1'b1, 1'b0);
        check_stats("pre_rst", 4, 2, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        jstate = 32'hFFFF;
        check_stats("mid_rst", 0, 0, 0);
        step("post_rst", DW_SYNC, 1'b1, 1'b0, D2, 1'b0, 1'b0, DW_SYNC, 1'b1, 1'b0, PRIM_NONE, 1'b0, 1'b0);
        step("post_rst2", DW_SYNC, 1'b1, 1'b0, D2, 1'b0, 1'b0, DW_SYNC, 1'b1, 1'b0, PRIM_NONE, 1'b0, 1'b0);
        step("post_cont", DW_SYNC, 1'b1, 1'b0, D2, 1'b0, 1'b0, DW_CONT, 1'b1, 1'b0, PRIM_NONE, 1'b0, 1'b0);
        step("seed_junk", DW_SYNC, 1'b1, 1'b0, D2, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, PRIM_NONE, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
